// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: forwarding select codes, hazard FSM
// state encoding and the default register address width.
package cpu_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  // Saturating increment shared by the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand ALU forwarding select: EX/MEM beats MEM/WB, register 0
// never forwards.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] exmem_rd,
  input  logic          exmem_regwrite,
  input  logic [AW-1:0] memwb_rd,
  input  logic          memwb_regwrite,
  output logic [1:0]    sel
);

  always_comb begin
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src))
      sel = FWD_EXMEM;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src))
      sel = FWD_MEMWB;
    else
      sel = FWD_RF;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller with memory-wait freeze.
// Optional statistics counters are built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int AW         = REG_AW,
  parameter int NSRC       = 2,
  parameter int LOAD_STALL = 1
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [AW-1:0]       exmem_rd_i,
  input  logic                exmem_regwrite_i,
  input  logic [AW-1:0]       memwb_rd_i,
  input  logic                memwb_regwrite_i,
  input  logic [NSRC*AW-1:0]  idex_src_i,
  input  logic [AW-1:0]       idex_rd_i,
  input  logic                idex_memread_i,
  input  logic [NSRC*AW-1:0]  ifid_src_i,
  input  logic [NSRC-1:0]     ifid_src_used_i,
  input  logic                mem_wait_i,
  output logic [2*NSRC-1:0]   fwd_sel_o,
  output logic                stall_o,
  output logic                bubble_o,
  output logic                freeze_o,
  output logic [31:0]         fwd_cnt_o,
  output logic [31:0]         stall_cnt_o
);

  localparam logic [1:0] RELOAD = 2'(LOAD_STALL - 1);

  for (genvar k = 0; k < NSRC; k++) begin : g_op
    fwd_select #(.AW(AW)) u_sel (
      .src            (idex_src_i[k*AW +: AW]),
      .exmem_rd       (exmem_rd_i),
      .exmem_regwrite (exmem_regwrite_i),
      .memwb_rd       (memwb_rd_i),
      .memwb_regwrite (memwb_regwrite_i),
      .sel            (fwd_sel_o[2*k +: 2])
    );
  end

  logic haz;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    haz = 1'b0;
    for (int k = 0; k < NSRC; k++)
      if (ifid_src_used_i[k] && (ifid_src_i[k*AW +: AW] == idex_rd_i))
        haz = 1'b1;
    haz = haz && idex_memread_i && (idex_rd_i != '0);
  end

  logic [0:0] state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       stall_raw;

  // Memory wait freezes everything: state and count hold, no stall issued.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stall_raw = 1'b0;
    if (!mem_wait_i) begin
      case (state)
        IDLE: if (haz) begin
          stall_raw = 1'b1;
          if (LOAD_STALL > 1) begin
            state_n = STALL;
            cnt_n   = RELOAD;
          end
        end
        default: begin
          stall_raw = 1'b1;
          cnt_n     = cnt - 2'd1;
          if (cnt == 2'd1) state_n = IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Gating with rst_n lets a reset abort a stall without waiting for a clock.
  assign stall_o  = rst_n & stall_raw;
  assign bubble_o = stall_o;
  assign freeze_o = mem_wait_i;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_cnt_q, stall_cnt_q;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (!mem_wait_i && (|fwd_sel_o)) fwd_cnt_q   <= sat_inc(fwd_cnt_q);
      if (stall_o)                     stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end
  assign fwd_cnt_o   = fwd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fwd_cnt_o   = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit, with LOAD_STALL=1 and
// LOAD_STALL=3 instances sharing stimulus but reset independently.
module tb_fwd_hazard_unit;

`ifdef FWD_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n1, rst_n3;
  logic [4:0]  exmem_rd, memwb_rd, idex_rd;
  logic        exmem_rw, memwb_rw, idex_memread, mem_wait;
  logic [9:0]  idex_src, ifid_src;
  logic [1:0]  ifid_used;

  logic [3:0]  fwd_sel1, fwd_sel3;
  logic        stall1, bubble1, freeze1, stall3, bubble3, freeze3;
  logic [31:0] fwd_cnt1, stall_cnt1, fwd_cnt3, stall_cnt3;

  int tests = 0;
  int fails = 0;
  int seen;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(5), .NSRC(2), .LOAD_STALL(1)) u_ls1 (
    .clk_i(clk), .rst_n(rst_n1),
    .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw),
    .memwb_rd_i(memwb_rd), .memwb_regwrite_i(memwb_rw),
    .idex_src_i(idex_src), .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
    .ifid_src_i(ifid_src), .ifid_src_used_i(ifid_used), .mem_wait_i(mem_wait),
    .fwd_sel_o(fwd_sel1), .stall_o(stall1), .bubble_o(bubble1), .freeze_o(freeze1),
    .fwd_cnt_o(fwd_cnt1), .stall_cnt_o(stall_cnt1)
  );

  fwd_hazard_unit #(.AW(5), .NSRC(2), .LOAD_STALL(3)) u_ls3 (
    .clk_i(clk), .rst_n(rst_n3),
    .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw),
    .memwb_rd_i(memwb_rd), .memwb_regwrite_i(memwb_rw),
    .idex_src_i(idex_src), .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
    .ifid_src_i(ifid_src), .ifid_src_used_i(ifid_used), .mem_wait_i(mem_wait),
    .fwd_sel_o(fwd_sel3), .stall_o(stall3), .bubble_o(bubble3), .freeze_o(freeze3),
    .fwd_cnt_o(fwd_cnt3), .stall_cnt_o(stall_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    exmem_rd = 5'd0; exmem_rw = 1'b0; memwb_rd = 5'd0; memwb_rw = 1'b0;
    idex_src = 10'd0; idex_rd = 5'd0; idex_memread = 1'b0;
    ifid_src = 10'd0; ifid_used = 2'b00; mem_wait = 1'b0;

    // Reset: stall suppressed even with a live hazard, forwarding and freeze stay live.
    #2;
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_src = {5'd5, 5'd0}; ifid_used = 2'b10;
    exmem_rd = 5'd3; exmem_rw = 1'b1; idex_src = {5'd0, 5'd3};
    #1;
    check("rst_stall1", {31'd0, stall1}, 32'd0);
    check("rst_bubble3", {31'd0, bubble3}, 32'd0);
    check("rst_fwdcnt3", fwd_cnt3, 32'd0);
    check("rst_stallcnt3", stall_cnt3, 32'd0);
    check("rst_fwd_sel", {28'd0, fwd_sel1}, 32'b0010);
    mem_wait = 1'b1; #1;
    check("rst_freeze", {31'd0, freeze1}, 32'd1);
    mem_wait = 1'b0; idex_memread = 1'b0;
    @(negedge clk);
    rst_n1 = 1'b1;

    // Forwarding priority and register-0 / RegWrite qualifiers.
    exmem_rd = 5'd3; exmem_rw = 1'b1; memwb_rd = 5'd3; memwb_rw = 1'b1;
    idex_src = {5'd3, 5'd3}; #1;
    check("fwd_exmem_prio", {28'd0, fwd_sel1}, 32'b1010);
    check("fwd_exmem_prio_ls3", {28'd0, fwd_sel3}, 32'b1010);
    exmem_rd = 5'd4; #1;
    check("fwd_memwb", {28'd0, fwd_sel1}, 32'b0101);
    exmem_rd = 5'd0; memwb_rw = 1'b0; idex_src = {5'd0, 5'd0}; #1;
    check("fwd_zero_reg", {28'd0, fwd_sel1}, 32'b0000);
    exmem_rd = 5'd3; exmem_rw = 1'b0; idex_src = {5'd0, 5'd3}; #1;
    check("fwd_no_regwrite", {28'd0, fwd_sel1}, 32'b0000);
    exmem_rd = 5'd7; exmem_rw = 1'b1; memwb_rd = 5'd9; memwb_rw = 1'b1;
    idex_src = {5'd7, 5'd9}; #1;
    check("fwd_mixed", {28'd0, fwd_sel1}, 32'b1001);
    memwb_rd = 5'd0; exmem_rw = 1'b0; idex_src = {5'd0, 5'd0}; #1;
    check("fwd_memwb_zero", {28'd0, fwd_sel1}, 32'b0000);
    memwb_rw = 1'b0;

    // Load-use with LOAD_STALL=1.
    next_cycle();
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_src = {5'd5, 5'd0}; ifid_used = 2'b10;
    @(negedge clk);
    check("ls1_stall", {31'd0, stall1}, 32'd1);
    check("ls1_bubble", {31'd0, bubble1}, 32'd1);
    check("ls1_nofreeze", {31'd0, freeze1}, 32'd0);
    next_cycle();
    idex_memread = 1'b0;
    @(negedge clk);
    check("ls1_one_cycle", {31'd0, stall1}, 32'd0);
    next_cycle();
    idex_memread = 1'b1; ifid_used = 2'b01;
    @(negedge clk);
    check("ls1_unused_src", {31'd0, stall1}, 32'd0);
    next_cycle();
    idex_rd = 5'd0; ifid_src = 10'd0; ifid_used = 2'b01;
    @(negedge clk);
    check("ls1_rd_zero", {31'd0, stall1}, 32'd0);
    next_cycle();
    idex_rd = 5'd5; ifid_src = {5'd5, 5'd0}; ifid_used = 2'b10; mem_wait = 1'b1;
    @(negedge clk);
    check("ls1_wait_nostall", {31'd0, stall1}, 32'd0);
    check("ls1_wait_freeze", {31'd0, freeze1}, 32'd1);
    next_cycle();
    mem_wait = 1'b0;
    @(negedge clk);
    check("ls1_after_wait", {31'd0, stall1}, 32'd1);
    next_cycle();
    idex_memread = 1'b0;

    // LOAD_STALL=3 with a two-cycle memory wait in the middle.
    rst_n1 = 1'b0;
    @(negedge clk);
    rst_n3 = 1'b1;
    next_cycle();
    seen = 0;
    idex_memread = 1'b1;
    @(negedge clk);
    check("ls3_c1_stall", {31'd0, stall3}, 32'd1);
    check("ls3_c1_bubble", {31'd0, bubble3}, 32'd1);
    seen += int'(stall3);
    next_cycle();
    idex_memread = 1'b0;
    @(negedge clk);
    check("ls3_c2_stall", {31'd0, stall3}, 32'd1);
    seen += int'(stall3);
    next_cycle();
    mem_wait = 1'b1;
    @(negedge clk);
    check("ls3_c3_frozen", {31'd0, stall3}, 32'd0);
    check("ls3_c3_freeze", {31'd0, freeze3}, 32'd1);
    check("ls3_c3_bubble", {31'd0, bubble3}, 32'd0);
    seen += int'(stall3);
    next_cycle();
    @(negedge clk);
    check("ls3_c4_frozen", {31'd0, stall3}, 32'd0);
    seen += int'(stall3);
    next_cycle();
    mem_wait = 1'b0;
    @(negedge clk);
    check("ls3_c5_stall", {31'd0, stall3}, 32'd1);
    seen += int'(stall3);
    next_cycle();
    @(negedge clk);
    check("ls3_c6_done", {31'd0, stall3}, 32'd0);
    seen += int'(stall3);
    check("ls3_total", seen, 32'd3);

    // Reset during the second stall cycle aborts the sequence.
    next_cycle();
    idex_memread = 1'b1;
    @(negedge clk);
    check("rs_c1_stall", {31'd0, stall3}, 32'd1);
    next_cycle();
    idex_memread = 1'b0;
    @(negedge clk);
    check("rs_c2_stall", {31'd0, stall3}, 32'd1);
    #1 rst_n3 = 1'b0;
    #1;
    check("rs_async_stall", {31'd0, stall3}, 32'd0);
    check("rs_async_bubble", {31'd0, bubble3}, 32'd0);
    check("rs_cnt_clear", stall_cnt3, 32'd0);
    @(negedge clk);
    rst_n3 = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen += int'(stall3);
    end
    check("rs_no_residual", seen, 32'd0);

    // Statistics: four forwarding cycles, one frozen forward, one 3-cycle stall.
    @(negedge clk);
    rst_n3 = 1'b0;
    #1 rst_n3 = 1'b1;
    exmem_rd = 5'd3; exmem_rw = 1'b1; idex_src = {5'd0, 5'd3};
    repeat (4) @(posedge clk);
    #1 mem_wait = 1'b1;
    next_cycle();
    mem_wait = 1'b0; exmem_rw = 1'b0;
    idex_memread = 1'b1;
    next_cycle();
    idex_memread = 1'b0;
    repeat (3) next_cycle();
    check("stats_fwd_cnt", fwd_cnt3, STATS ? 32'd4 : 32'd0);
    check("stats_stall_cnt", stall_cnt3, STATS ? 32'd3 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
